// File: rtl/alu_ctrl_seq.sv
// Multicycle control sequencer for the ALU path: fetch, decode, execute and
// writeback for add/sub/and/addi/beq, plus a one-cycle exception pulse.
module alu_ctrl_seq #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       mem_read,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ab_load,
    output logic       alu_out_load,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       exc,
    output logic       exc_cause
);

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC_R = 4'd3,
        ST_EXEC_I = 4'd4,
        ST_WB_R   = 4'd5,
        ST_WB_I   = 4'd6,
        ST_BRANCH = 4'd7,
        ST_EXCP   = 4'd8
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);
    localparam logic [2:0] OP_PASS   = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b001;
    localparam logic [2:0] OP_SUB    = 3'b010;
    localparam logic [2:0] OP_AND    = 3'b011;

    // Returns the ALU op for a supported R-type funct, OP_PASS marks it illegal.
    function automatic logic [2:0] rtype_op(input logic [5:0] f);
        logic [2:0] r;
        case (f)
            6'h20:   r = OP_ADD;
            6'h22:   r = OP_SUB;
            6'h24:   r = OP_AND;
            default: r = OP_PASS;
        endcase
        return r;
    endfunction

    state_t      state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic        cause_r, cause_s;
    logic [2:0]  rop_r, rop_s;
    logic [15:0] ctrl_s, ctrl_r;

    // State, wait counter, latched R-type op and exception cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RST;
            cnt_r   <= 3'd0;
            cause_r <= 1'b0;
            rop_r   <= OP_PASS;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            cause_r <= cause_s;
            rop_r   <= rop_s;
        end
    end

    // Next-state logic; every entry into FETCH clears the wait counter.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        cause_s = cause_r;
        rop_s   = rop_r;
        case (state_r)
            ST_RST: begin
                state_s = ST_FETCH;
                cnt_s   = 3'd0;
            end
            ST_FETCH: begin
                if (cnt_r == WAIT_LAST) begin
                    state_s = ST_DECODE;
                    cnt_s   = 3'd0;
                end else if (cnt_r != 3'd7) begin
                    cnt_s = cnt_r + 3'd1;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_DECODE: begin
                rop_s = rtype_op(funct);
                if ((opcode == 6'h00) && (rtype_op(funct) != OP_PASS)) begin
                    state_s = ST_EXEC_R;
                end else if (opcode == 6'h08) begin
                    state_s = ST_EXEC_I;
                end else if (opcode == 6'h04) begin
                    state_s = ST_BRANCH;
                end else begin
                    state_s = ST_EXCP;
                    cause_s = 1'b1;
                end
            end
            ST_EXEC_R: begin
                // overflow has no meaning for a logical and
                if (overflow && (rop_r != OP_AND)) begin
                    state_s = ST_EXCP;
                    cause_s = 1'b0;
                end else begin
                    state_s = ST_WB_R;
                end
            end
            ST_EXEC_I: begin
                if (overflow) begin
                    state_s = ST_EXCP;
                    cause_s = 1'b0;
                end else begin
                    state_s = ST_WB_I;
                end
            end
            ST_WB_R, ST_WB_I, ST_BRANCH, ST_EXCP: begin
                state_s = ST_FETCH;
                cnt_s   = 3'd0;
            end
            default: begin
                state_s = ST_RST;
                cnt_s   = 3'd0;
            end
        endcase
    end

    // Decodes the controls for the state about to be entered so they can be
    // registered and still line up with that state.
    always_comb begin
        ctrl_s = 16'h0000;
        case (state_s)
            ST_FETCH: begin
                ctrl_s[14:13] = 2'b01;
                ctrl_s[12:10] = OP_ADD;
                ctrl_s[9]     = 1'b1;
                if (cnt_s == WAIT_LAST) begin
                    ctrl_s[8] = 1'b1;
                    ctrl_s[7] = 1'b1;
                end else begin
                    ctrl_s[8] = 1'b0;
                    ctrl_s[7] = 1'b0;
                end
            end
            ST_DECODE: begin
                ctrl_s[14:13] = 2'b11;
                ctrl_s[12:10] = OP_ADD;
                ctrl_s[5]     = 1'b1;
                ctrl_s[4]     = 1'b1;
            end
            ST_EXEC_R: begin
                ctrl_s[15]    = 1'b1;
                ctrl_s[14:13] = 2'b00;
                ctrl_s[12:10] = rop_s;
                ctrl_s[4]     = 1'b1;
            end
            ST_EXEC_I: begin
                ctrl_s[15]    = 1'b1;
                ctrl_s[14:13] = 2'b10;
                ctrl_s[12:10] = OP_ADD;
                ctrl_s[4]     = 1'b1;
            end
            ST_WB_R: begin
                ctrl_s[3] = 1'b1;
                ctrl_s[2] = 1'b1;
            end
            ST_WB_I: begin
                ctrl_s[3] = 1'b1;
                ctrl_s[2] = 1'b0;
            end
            ST_BRANCH: begin
                ctrl_s[15]    = 1'b1;
                ctrl_s[14:13] = 2'b00;
                ctrl_s[12:10] = OP_SUB;
                ctrl_s[6]     = 1'b1;
            end
            ST_EXCP: begin
                ctrl_s[1] = 1'b1;
                ctrl_s[0] = cause_s;
            end
            default: begin
                ctrl_s = 16'h0000;
            end
        endcase
    end

    // Output register; cleared together with the state so RST shows all zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r <= 16'h0000;
        end else begin
            ctrl_r <= ctrl_s;
        end
    end

    assign alu_src_a     = ctrl_r[15];
    assign alu_src_b     = ctrl_r[14:13];
    assign alu_op        = ctrl_r[12:10];
    assign mem_read      = ctrl_r[9];
    assign ir_write      = ctrl_r[8];
    assign pc_write      = ctrl_r[7];
    assign pc_write_cond = ctrl_r[6];
    assign ab_load       = ctrl_r[5];
    assign alu_out_load  = ctrl_r[4];
    assign reg_write     = ctrl_r[3];
    assign reg_dst       = ctrl_r[2];
    assign exc           = ctrl_r[1];
    assign exc_cause     = ctrl_r[0];

endmodule
